// File: rtl/param_serializer_pkg.sv
// Shared types and helpers for the parametrised parallel-to-serial converter.
package param_serializer_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Length code 0 encodes a full-width word.
    function automatic int len_decode(input int mod, input int data_w);
        return (mod == 0) ? data_w : mod;
    endfunction

    function automatic logic is_legal(input int mod, input int min_len);
        return (mod == 0) || (mod >= min_len);
    endfunction

endpackage

// File: rtl/ser_word_slot.sv
// Single-entry holding register for the word queued behind the active one.
module ser_word_slot #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              wr_lsb_first,
    output logic [DATA_W-1:0] data,
    output logic [LEN_W-1:0]  len,
    output logic              lsb_first,
    output logic              valid,
    output logic              ready
);

    logic valid_next;

    assign valid_next = push || (valid && !pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data      <= '0;
            len       <= '0;
            lsb_first <= 1'b0;
            valid     <= 1'b0;
            ready     <= 1'b1;
        end else begin
            if (push) begin
                data      <= wr_data;
                len       <= wr_len;
                lsb_first <= wr_lsb_first;
            end
            valid <= valid_next;
            ready <= !valid_next;
        end
    end

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with variable length, bit order select,
// ready/valid on both sides and a one-word pending slot for gapless streaming.
module param_serializer
    import param_serializer_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int MIN_LEN = 3,
    localparam int MOD_W   = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_lsb_first_i,
    input  logic              data_val_i,
    output logic              data_ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    input  logic              ser_ready_i,
    output logic              busy_o
);

    localparam int LEN_W = MOD_W + 1;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              lsb_q;
    logic [LEN_W-1:0]  bits_left;

    logic [LEN_W-1:0]  in_len;
    logic              in_legal;
    logic              take, accept, word_done, load_pend, load_new, push;

    logic [DATA_W-1:0] slot_data;
    logic [LEN_W-1:0]  slot_len;
    logic              slot_lsb, slot_valid;

    logic [DATA_W-1:0] src_data;
    logic [LEN_W-1:0]  src_len;
    logic              src_lsb, src_first;

    assign in_len   = LEN_W'(len_decode(int'(data_mod_i), DATA_W));
    assign in_legal = is_legal(int'(data_mod_i), MIN_LEN);

    assign take   = ser_data_val_o && ser_ready_i;
    assign accept = data_val_i && data_ready_o && in_legal;

    // The active path frees up at this edge; a waiting word (pending first,
    // else the one arriving now) goes straight to the output with no gap.
    assign word_done = (state == IDLE) || (take && bits_left == '0);
    assign load_pend = word_done && slot_valid;
    assign load_new  = word_done && !slot_valid && accept;
    assign push      = accept && !load_new;

    assign src_data  = slot_valid ? slot_data : data_i;
    assign src_len   = slot_valid ? slot_len  : in_len;
    assign src_lsb   = slot_valid ? slot_lsb  : data_lsb_first_i;
    assign src_first = src_lsb ? src_data[0] : src_data[DATA_W-1];

    ser_word_slot #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_slot (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push        (push),
        .pop         (load_pend),
        .wr_data     (data_i),
        .wr_len      (in_len),
        .wr_lsb_first(data_lsb_first_i),
        .data        (slot_data),
        .len         (slot_len),
        .lsb_first   (slot_lsb),
        .valid       (slot_valid),
        .ready       (data_ready_o)
    );

    // bits_left counts bits still in shreg, excluding the one on the output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            shreg          <= '0;
            lsb_q          <= 1'b0;
            bits_left      <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            ser_last_o     <= 1'b0;
        end else if (load_pend || load_new) begin
            state          <= SHIFT;
            ser_data_o     <= src_first;
            ser_data_val_o <= 1'b1;
            ser_last_o     <= (src_len == LEN_W'(1));
            shreg          <= src_lsb ? (src_data >> 1) : (src_data << 1);
            lsb_q          <= src_lsb;
            bits_left      <= src_len - LEN_W'(1);
        end else if (take && bits_left != '0) begin
            ser_data_o <= lsb_q ? shreg[0] : shreg[DATA_W-1];
            ser_last_o <= (bits_left == LEN_W'(1));
            shreg      <= lsb_q ? (shreg >> 1) : (shreg << 1);
            bits_left  <= bits_left - LEN_W'(1);
        end else if (take) begin
            state          <= IDLE;
            ser_data_val_o <= 1'b0;
            ser_last_o     <= 1'b0;
        end
    end

    assign busy_o = (state == SHIFT) || slot_valid || ser_data_val_o;

endmodule

// File: tb/tb_param_serializer.sv
// Directed and random stimulus against a bit-queue reference model of the serializer.
module tb_param_serializer;

    localparam int DATA_W  = 16;
    localparam int MIN_LEN = 3;
    localparam int MOD_W   = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [DATA_W-1:0] data_i;
    logic [MOD_W-1:0]  data_mod_i;
    logic              data_lsb_first_i;
    logic              data_val_i;
    logic              data_ready_o;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              ser_last_o;
    logic              ser_ready_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    param_serializer #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .data_i          (data_i),
        .data_mod_i      (data_mod_i),
        .data_lsb_first_i(data_lsb_first_i),
        .data_val_i      (data_val_i),
        .data_ready_o    (data_ready_o),
        .ser_data_o      (ser_data_o),
        .ser_data_val_o  (ser_data_val_o),
        .ser_last_o      (ser_last_o),
        .ser_ready_i     (ser_ready_i),
        .busy_o          (busy_o)
    );

    typedef struct packed {
        logic b;
        logic last;
    } sbit_t;

    sbit_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    nwords = 0;
    logic  accepted = 1'b0;
    logic  prev_val = 1'b0, prev_rdy = 1'b0, prev_data = 1'b0, prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected serial bits of one word, in the order the consumer must see them.
    task automatic queue_word(input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] mod, input logic lsb);
        int    len;
        sbit_t e;
        if (mod != 0 && mod < MIN_LEN) return;
        len = (mod == 0) ? DATA_W : int'(mod);
        for (int i = 0; i < len; i++) begin
            e.b    = lsb ? d[i] : d[DATA_W-1-i];
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
        nwords++;
    endtask

    // Observe at the falling edge, update the model, then advance past the rising edge.
    task automatic tick();
        sbit_t e;
        @(negedge clk_i);
        accepted = 1'b0;
        chk("ser_val", ser_data_val_o, exp_q.size() != 0);
        chk("busy", busy_o, exp_q.size() != 0);
        chk("data_ready", data_ready_o, nwords < 2);
        if (prev_val && !prev_rdy) begin
            chk("hold_data", ser_data_o, prev_data);
            chk("hold_last", ser_last_o, prev_last);
        end
        if (ser_data_val_o && ser_ready_i && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ser_bit", ser_data_o, e.b);
            chk("ser_last", ser_last_o, e.last);
            if (e.last) nwords--;
        end
        prev_val  = ser_data_val_o;
        prev_rdy  = ser_ready_i;
        prev_data = ser_data_o;
        prev_last = ser_last_o;
        if (data_val_i && data_ready_o) begin
            accepted = 1'b1;
            queue_word(data_i, data_mod_i, data_lsb_first_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] mod, input logic lsb);
        data_i           = d;
        data_mod_i       = mod;
        data_lsb_first_i = lsb;
        data_val_i       = 1'b1;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (accepted) break;
        end
        chk("send_accept", accepted, 1);
        data_val_i = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        rst_n_i          = 1'b0;
        data_i           = '0;
        data_mod_i       = '0;
        data_lsb_first_i = 1'b0;
        data_val_i       = 1'b0;
        ser_ready_i      = 1'b1;
        #12;
        chk("rst_ser_data", ser_data_o, 0);
        chk("rst_ser_val", ser_data_val_o, 0);
        chk("rst_ser_last", ser_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", data_ready_o, 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        send(16'hA5F0, 4'd4, 1'b0);
        drain();
        send(16'h8001, 4'd0, 1'b0);
        drain();
        send(16'hFFFF, 4'd1, 1'b0);
        send(16'hFFFF, 4'd2, 1'b1);
        drain();
        send(16'h0006, 4'd3, 1'b1);
        drain();

        send(16'hE000, 4'd3, 1'b0);
        send(16'h4000, 4'd3, 1'b0);
        send(16'hA000, 4'd3, 1'b0);
        drain();

        // Stall mid-word, then reset mid-word.
        send(16'hA5F0, 4'd0, 1'b0);
        tick();
        tick();
        ser_ready_i = 1'b0;
        tick();
        tick();
        tick();
        ser_ready_i = 1'b1;
        tick();
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_ser_data", ser_data_o, 0);
        chk("mid_rst_ser_val", ser_data_val_o, 0);
        chk("mid_rst_ser_last", ser_last_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", data_ready_o, 1);
        exp_q.delete();
        nwords   = 0;
        prev_val = 1'b0;
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        tick();
        send(16'h3C5A, 4'd0, 1'b1);
        drain();

        for (int c = 0; c < 1500; c++) begin
            data_i           = DATA_W'($urandom);
            data_mod_i       = MOD_W'($urandom);
            data_lsb_first_i = 1'($urandom);
            data_val_i       = ($urandom % 2) != 0;
            ser_ready_i      = ($urandom % 4) != 0;
            tick();
        end
        data_val_i  = 1'b0;
        ser_ready_i = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
